coloring_fb_bot: RTL and testbench

Frame-buffer colouring stage for the bottom half of the screen in the rendering pipeline. It sits directly downstream of `zculling_bot` and consumes its 32-bit pixel stream through an ap_vld/ap_ack word handshake. It paints each surviving pixel into an on-chip 8-bit-per-pixel frame buffer. After the final triangle it streams the whole half-frame out, four pixels per word, toward the output leaf interface, clearing the buffer as it goes.

---
 rtl/rendering_pkg.sv | 33 +++
 rtl/fb_ram.sv | 33 +++
 rtl/coloring_fb_bot.sv | 170 +++++++++++++++++
 tb/tb_coloring_fb_bot.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rendering_pkg.sv
// Shared definitions for the rendering pipeline stages: word field
// positions, the colouring FSM state type and frame-buffer sizing helpers.
package rendering_pkg;

  // Header word: {last[31], rsvd[30:16], count[15:0]}
  localparam int HDR_LAST_BIT = 31;
  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_W    = 16;

  // Pixel word: {rsvd[31:24], color[23:16], y[15:8], x[7:0]}
  localparam int PIX_X_LSB = 0;
  localparam int PIX_Y_LSB = 8;
  localparam int PIX_C_LSB = 16;
  localparam int PIX_F_W   = 8;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_PIXEL,
    S_DUMP_RD,
    S_DUMP_OUT
  } state_e;

  // Four 8-bit pixels per 32-bit frame-buffer word.
  function automatic int fb_words(input int width, input int rows);
    return (width * rows) / 4;
  endfunction

  function automatic int fb_addr_w(input int width, input int rows);
    return $clog2((width * rows) / 4);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port frame-buffer RAM: 32-bit words split into four byte lanes,
// per-lane write enable, registered read (1-cycle latency), no reset.
module fb_ram #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Byte-lane write and read-enabled registered read; rd_q holds between reads.
    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        mem[addr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        rd_q <= mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = rd_q;
  end

endmodule

// File: rtl/coloring_fb_bot.sv
// Bottom-half frame-buffer colouring stage: clears the buffer after reset,
// paints accepted pixels, and after the last triangle streams the buffer
// out four pixels per word while clearing each word as it is acknowledged.
module coloring_fb_bot
  import rendering_pkg::*;
#(
  parameter int FB_WIDTH = 256,
  parameter int FB_ROWS  = 128,
  parameter int Y_OFFSET = 128
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [31:0] Input_1_V_V,
  input  logic        Input_1_V_V_ap_vld,
  output logic        Input_1_V_V_ap_ack,
  output logic [31:0] Output_1_V_V,
  output logic        Output_1_V_V_ap_vld,
  input  logic        Output_1_V_V_ap_ack
);

  localparam int WORDS = fb_words(FB_WIDTH, FB_ROWS);
  localparam int AW    = fb_addr_w(FB_WIDTH, FB_ROWS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;     // clear-sweep and dump address
  logic [HDR_CNT_W-1:0] remain_q, remain_d; // pixels left in current triangle
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  logic          ram_we, ram_re;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  logic [HDR_CNT_W-1:0] hdr_count;
  logic                 hdr_last;
  logic [7:0]           pix_x, pix_y, pix_c;
  logic [8:0]           y_rel;
  logic                 pix_in_range;
  logic [AW-1:0]        pix_addr;
  logic [3:0]           pix_be;

  assign hdr_count = Input_1_V_V[HDR_CNT_LSB +: HDR_CNT_W];
  assign hdr_last  = Input_1_V_V[HDR_LAST_BIT];
  assign pix_x     = Input_1_V_V[PIX_X_LSB +: PIX_F_W];
  assign pix_y     = Input_1_V_V[PIX_Y_LSB +: PIX_F_W];
  assign pix_c     = Input_1_V_V[PIX_C_LSB +: PIX_F_W];

  // Row relative to the buffer, computed 9 bits wide so rows above the
  // buffer cannot alias into it; bounds are checked on the widened values.
  assign y_rel        = {1'b0, pix_y} - 9'(Y_OFFSET);
  assign pix_in_range = ({1'b0, pix_y} >= 9'(Y_OFFSET)) &&
                        (y_rel < 9'(FB_ROWS)) &&
                        ({1'b0, pix_x} < 9'(FB_WIDTH));
  assign pix_addr     = AW'(int'(y_rel) * (FB_WIDTH / 4) + int'(pix_x) / 4);
  assign pix_be       = 4'b0001 << pix_x[1:0];

  fb_ram #(.DEPTH(WORDS), .AW(AW)) u_fb_ram (
    .clk   (ap_clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State and counter registers; reset restarts the clear sweep.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_CLEAR;
      addr_q   <= '0;
      remain_q <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  // Next-state, RAM port steering and handshake outputs.
  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    remain_d            = remain_q;
    last_d              = last_q;
    done_d              = 1'b0;
    ram_we              = 1'b0;
    ram_re              = 1'b0;
    ram_be              = 4'hF;
    ram_addr            = addr_q;
    ram_wdata           = '0;
    Input_1_V_V_ap_ack  = 1'b0;
    ap_ready            = 1'b0;
    Output_1_V_V_ap_vld = 1'b0;
    case (state_q)
      S_CLEAR: begin
        ram_we = 1'b1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_IDLE: begin
        Input_1_V_V_ap_ack = ap_start;
        if (ap_start && Input_1_V_V_ap_vld) begin
          ap_ready = 1'b1;
          remain_d = hdr_count;
          last_d   = hdr_last;
          if (hdr_count != '0) begin
            state_d = S_PIXEL;
          end else if (hdr_last) begin
            state_d = S_DUMP_RD;
          end
        end
      end
      S_PIXEL: begin
        Input_1_V_V_ap_ack = 1'b1;
        if (Input_1_V_V_ap_vld) begin
          if (pix_in_range) begin
            ram_we    = 1'b1;
            ram_be    = pix_be;
            ram_addr  = pix_addr;
            ram_wdata = {4{pix_c}};
          end
          remain_d = remain_q - 1'b1;
          if (remain_q == HDR_CNT_W'(1)) begin
            state_d = last_q ? S_DUMP_RD : S_IDLE;
          end
        end
      end
      S_DUMP_RD: begin
        ram_re  = 1'b1;
        state_d = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        Output_1_V_V_ap_vld = 1'b1;
        if (Output_1_V_V_ap_ack) begin
          ram_we = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_DUMP_RD;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // RAM read data is only presented while a dump word is offered.
  assign Output_1_V_V = (state_q == S_DUMP_OUT) ? ram_rdata : '0;
  assign ap_idle      = (state_q == S_IDLE);
  assign ap_done      = done_q;

endmodule

// File: tb/tb_coloring_fb_bot.sv
// Scoreboard bench for coloring_fb_bot: a pixel-array reference model
// produces expected dump words, a monitor pops and compares them.
module tb_coloring_fb_bot;

  // 80 rows keeps the row upper bound inside the 8-bit y range.
  localparam int FB_WIDTH = 256;
  localparam int FB_ROWS  = 80;
  localparam int Y_OFFSET = 128;
  localparam int WORDS    = FB_WIDTH * FB_ROWS / 4;
  localparam int WAIT_MAX = 40000;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [31:0] in_data;
  logic        in_vld, in_ack;
  logic [31:0] out_data;
  logic        out_vld, out_ack;

  always #5 ap_clk = ~ap_clk;

  coloring_fb_bot #(.FB_WIDTH(FB_WIDTH), .FB_ROWS(FB_ROWS), .Y_OFFSET(Y_OFFSET)) dut (
    .ap_clk              (ap_clk),
    .ap_rst_n            (ap_rst_n),
    .ap_start            (ap_start),
    .ap_done             (ap_done),
    .ap_idle             (ap_idle),
    .ap_ready            (ap_ready),
    .Input_1_V_V         (in_data),
    .Input_1_V_V_ap_vld  (in_vld),
    .Input_1_V_V_ap_ack  (in_ack),
    .Output_1_V_V        (out_data),
    .Output_1_V_V_ap_vld (out_vld),
    .Output_1_V_V_ap_ack (out_ack)
  );

  int checks = 0;
  int errors = 0;
  int ack_pct = 100;
  int nwords = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pix_q[$];
  logic [7:0]  fb_m [FB_ROWS][FB_WIDTH];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: paint one pixel if it lands inside the half-frame.
  function automatic void model_pixel(input logic [31:0] w);
    int x, y;
    x = int'(w[7:0]);
    y = int'(w[15:8]);
    if (y >= Y_OFFSET && y < Y_OFFSET + FB_ROWS && x < FB_WIDTH)
      fb_m[y - Y_OFFSET][x] = w[23:16];
  endfunction

  // Snapshot the model frame row-major, four pixels per word, then clear it.
  function automatic void push_dump();
    for (int r = 0; r < FB_ROWS; r++) begin
      for (int k = 0; k < FB_WIDTH / 4; k++) begin
        exp_q.push_back({fb_m[r][4*k+3], fb_m[r][4*k+2], fb_m[r][4*k+1], fb_m[r][4*k]});
      end
      for (int x = 0; x < FB_WIDTH; x++) fb_m[r][x] = 8'h00;
    end
  endfunction

  task automatic send_word(input logic [31:0] w, input bit is_hdr);
    bit done;
    done = 1'b0;
    @(negedge ap_clk);
    in_data = w;
    in_vld  = 1'b1;
    for (int t = 0; t < WAIT_MAX && !done; t++) begin
      #1;
      if (in_ack) begin
        if (is_hdr) check("ap_ready_on_header", 32'(ap_ready), 32'd1);
        @(posedge ap_clk);
        #1;
        in_vld = 1'b0;
        done   = 1'b1;
      end else begin
        @(negedge ap_clk);
      end
    end
    if (!done) begin
      check("input_accept_timeout", 32'd0, 32'd1);
      in_vld = 1'b0;
    end
  endtask

  task automatic send_frame(input bit last, input bit gaps);
    send_word({last, 15'd0, 16'(pix_q.size())}, 1'b1);
    if (pix_q.size() == 0 && last) push_dump();
    foreach (pix_q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge ap_clk);
      send_word(pix_q[i], 1'b0);
      model_pixel(pix_q[i]);
    end
    if (pix_q.size() != 0 && last) push_dump();
    pix_q.delete();
  endtask

  task automatic random_pixels(input int n);
    logic [31:0] w, prev;
    prev = 32'h0;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[15:8] = 8'(Y_OFFSET + $urandom_range(0, FB_ROWS - 1));
      if (i > 0 && $urandom_range(0, 4) == 0) w[15:0] = prev[15:0];
      pix_q.push_back(w);
      prev = w;
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < WAIT_MAX && exp_q.size() != 0; t++) @(negedge ap_clk);
    if (exp_q.size() != 0) check("dump_drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge ap_clk);
  endtask

  // Monitor: random output ack, pops expected words on each transfer,
  // checks hold-while-stalled and the ap_done pulse after each full dump.
  initial begin
    logic        prev_vld, prev_xfer, xfer, done_exp;
    logic [31:0] prev_data, exp;
    int          dump_cnt;
    out_ack = 1'b0;
    prev_vld = 1'b0; prev_xfer = 1'b0; done_exp = 1'b0;
    prev_data = '0; dump_cnt = 0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        out_ack = 1'b0; prev_vld = 1'b0; prev_xfer = 1'b0;
        done_exp = 1'b0; dump_cnt = 0;
        continue;
      end
      if (done_exp || ap_done === 1'b1) check("ap_done_pulse", 32'(ap_done), 32'(done_exp));
      done_exp = 1'b0;
      if (prev_vld && !prev_xfer) begin
        check("out_vld_hold", 32'(out_vld), 32'd1);
        check("out_data_hold", out_data, prev_data);
      end
      out_ack = ($urandom_range(0, 99) < ack_pct);
      xfer = out_vld && out_ack;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_word", out_data, 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("dump_word", out_data, exp);
        end
        nwords++;
        dump_cnt++;
        if (dump_cnt == WORDS) begin
          dump_cnt = 0;
          done_exp = 1'b1;
        end
      end
      prev_vld = out_vld; prev_data = out_data; prev_xfer = xfer;
    end
  end

  initial begin
    int bad, base;
    for (int r = 0; r < FB_ROWS; r++)
      for (int x = 0; x < FB_WIDTH; x++) fb_m[r][x] = 8'h00;
    ap_rst_n = 1'b0; ap_start = 1'b0; in_vld = 1'b0; in_data = '0;
    #3;
    check("rst_ap_idle", 32'(ap_idle), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ack", 32'(in_ack), 32'd0);
    check("rst_ap_done", 32'(ap_done), 32'd0);

    // Clear sweep with a count=0/last header already waiting.
    repeat (3) @(negedge ap_clk);
    ap_start = 1'b1; in_vld = 1'b1; in_data = 32'h8000_0000;
    ap_rst_n = 1'b1;
    #1;
    bad = (in_ack || ap_idle) ? 1 : 0;
    for (int k = 1; k < WORDS; k++) begin
      @(posedge ap_clk); #1;
      if (in_ack || ap_idle) bad++;
    end
    check("clear_ack_low_cycles", 32'(bad), 32'd0);
    @(posedge ap_clk); #1;
    check("idle_after_sweep", 32'(ap_idle), 32'd1);
    check("hdr_ack_after_sweep", 32'(in_ack), 32'd1);
    send_frame(1'b1, 1'b0);

    // count=0, last=0 header leaves the block idle.
    send_frame(1'b0, 1'b0);
    @(negedge ap_clk); #1;
    check("idle_after_empty_hdr", 32'(ap_idle), 32'd1);

    // Two triangles: corner pixels, an overwrite, and rows/columns at the bounds.
    pix_q = '{32'h0055_8000, 32'h00AA_8003, 32'h0011_C80A};
    send_frame(1'b0, 1'b0);
    pix_q = '{32'h0077_7F00, 32'h0099_0000, 32'h0033_D005, 32'h0022_C80A, 32'hFF66_CFFF};
    send_frame(1'b1, 1'b0);
    #1;
    check("dump_rd_gap_vld", 32'(out_vld), 32'd0);
    @(posedge ap_clk); #1;
    check("first_out_latency_vld", 32'(out_vld), 32'd1);
    wait_drain();

    // ap_start low blocks a waiting header.
    ap_start = 1'b0;
    @(negedge ap_clk);
    in_data = 32'h8000_0001; in_vld = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    check("start_low_in_ack", 32'(in_ack), 32'd0);
    check("start_low_ap_ready", 32'(ap_ready), 32'd0);
    check("start_low_idle", 32'(ap_idle), 32'd1);
    in_vld = 1'b0; ap_start = 1'b1;

    // Random frame under 30% output backpressure, then an immediate empty dump.
    ack_pct = 30;
    random_pixels(40);
    send_frame(1'b0, 1'b1);
    random_pixels(40);
    send_frame(1'b1, 1'b1);
    send_frame(1'b1, 1'b0);
    ack_pct = 100;
    wait_drain();

    // Reset in the middle of a dump, then a single-pixel frame.
    pix_q = '{32'h0044_9010};
    send_frame(1'b1, 1'b0);
    base = nwords;
    for (int t = 0; t < WAIT_MAX && nwords < base + 2000; t++) @(posedge ap_clk);
    check("mid_dump_progress", 32'(nwords >= base + 2000), 32'd1);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("async_rst_out_vld", 32'(out_vld), 32'd0);
    check("async_rst_out_data", out_data, 32'd0);
    check("async_rst_idle", 32'(ap_idle), 32'd0);
    check("async_rst_in_ack", 32'(in_ack), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    pix_q = '{32'h00C3_964D};
    send_frame(1'b1, 1'b0);
    wait_drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
